instr_encoder_loader: RTL and testbench
=======================================

// Module: instr_encoder_loader
// PURPOSE
//  Boot-time program loader and the encode side of the control decoder's ISA.
//  - Accepts decoded instruction fields over a valid/ready stream.
//  - Packs each beat into the 16-bit instruction word that the decoder consumes.
//  - Writes words to instruction memory at consecutive addresses from 0.
//  - Holds the CPU (cpu_hold) until the program is fully written.
// PARAMETERS
//  IMEM_AW  8  instruction-memory address width; capacity DEPTH = 2**IMEM_AW words
// PORTS
//  clk          in   1        single clock, rising edge
//  rst          in   1        asynchronous, active-high reset
//  start        in   1        1-cycle pulse: begin a new load session
//  in_valid     in   1        input beat valid
//  in_ready     out  1        loader can accept a beat
//  in_opcode    in   4        instr[15:12]
//  in_rs        in   3        source register
//  in_rt        in   3        target register
//  in_rd        in   3        destination register (R-type)
//  in_funct3    in   3        R-type function
//  in_imm       in   12       imm6=[5:0], imm8=[7:0], CALL target=[11:0]
//  in_last      in   1        beat is the final instruction
//  imem_we      out  1        instruction-memory write strobe
//  imem_addr    out  IMEM_AW  write address
//  imem_wdata   out  16       encoded instruction
//  cpu_hold     out  1        1 = CPU held (pc_en low)
//  done         out  1        1-cycle pulse when the session completes
//  count        out  IMEM_AW+1  words written this session
//  err_overflow out  1        sticky: a beat arrived with memory full
// BEHAVIOUR
//  Encoding (unused inputs ignored; unused word bits 0):
//   op 0000/0001  : {op, rs, rt, rd, funct3}
//   op 0100-1100  : {op, rs, rt, imm[5:0]}
//   op 0010/0011  : {op, rt, 1'b0, imm[7:0]}
//   op 1101       : {op, imm[11:0]}
//   op 1110/1111  : {op, 12'h000}
//  Reset values: in_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, cpu_hold=1,
//   done=0, count=0, err_overflow=0, state=IDLE.
//  FSM IDLE -> LOAD -> DRAIN -> DONE -> IDLE.
//   IDLE : in_ready=0. On start, clear count, addr, err_overflow; go to LOAD.
//          cpu_hold keeps its previous value.
//   LOAD : cpu_hold=1, in_ready=1. Throughput 1 beat/cycle.
//          A beat is accepted when in_valid & in_ready. Accepted word is registered.
//          Next cycle: imem_we=1, imem_addr=count, then count++.
//          Write latency = exactly 1 cycle after accept.
//          Accept with in_last: go to DRAIN, in_ready=0.
//   DRAIN: completes the pending write (plus the AUTO_HALT write if any); then DONE.
//   DONE : done=1 for one cycle, cpu_hold=0; go to IDLE.
//  Full memory: a beat accepted while count==DEPTH is dropped (no imem_we).
//   err_overflow set, sticky until next start. Session continues until in_last.
//  start while in LOAD/DRAIN/DONE: ignored.
//  in_valid in IDLE: not accepted, no effect.
//  Reset mid-session: FSM to IDLE, cpu_hold=1, outputs to reset values.
//   Words already written to imem are not cleared.
//  count never wraps; saturates at DEPTH.
// CONFIGURATION
//  AUTO_HALT_EN defined:
//   - If the in_last beat's opcode != 1111, DRAIN writes 16'hF000 (HALT) at the next address.
//   - Takes one extra cycle; count includes this word.
//   - If no room, the HALT write is skipped and err_overflow is set.
//  AUTO_HALT_EN undefined:
//   - No appended word. DRAIN lasts exactly 1 cycle.
// TESTING
//  T1 start; beats ADD(op0,rs1,rt2,rd3,f0), ADDI(op4,rs1,rt2,imm=-3), HALT last
//     -> imem[0]=16'h0298, imem[1]=16'h42BD, imem[2]=16'hF000;
//        count=3, done pulse, cpu_hold 1->0.
//  T2 LHI rt=5 imm8=8'hAB, then CALL target=12'h123 with last
//     -> words 16'h2AAB, 16'hD123;
//        without AUTO_HALT_EN count=2; with it imem[2]=16'hF000, count=3.
//  T3 in_valid toggling randomly during LOAD
//     -> one write per accepted beat, in order;
//        each imem_we exactly 1 cycle after its accept.
//  T4 IMEM_AW=2, send 6 beats, last on beat 6
//     -> 4 words written; beats 5-6 dropped; err_overflow=1; count=4; done pulses.
//  T5 assert rst after 2 of 5 beats accepted
//     -> immediately cpu_hold=1, imem_we=0, count=0, IDLE;
//        a new start then loads from address 0.
//  T6 start pulsed during LOAD; in_valid asserted in IDLE
//     -> no restart, count unchanged, no imem_we from the IDLE beat.

Source files
------------

// File: rtl/instr_encoder_loader.sv
// instr_encoder_loader
//   Boot-time program loader. Accepts decoded instruction fields over a
//   valid/ready stream and packs each beat into a 16-bit instruction word.
//   Words are written to instruction memory at consecutive addresses from 0.
//   The CPU is held until the whole program has been written.
//
//   Optional feature macro: AUTO_HALT_EN
//     When defined, a HALT word (16'hF000) is appended after the last beat
//     unless that beat already was a HALT.
//     If memory is full at that point, the HALT is skipped and err_overflow
//     is raised.
module instr_encoder_loader #(
    parameter int IMEM_AW = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [3:0]         in_opcode,
    input  logic [2:0]         in_rs,
    input  logic [2:0]         in_rt,
    input  logic [2:0]         in_rd,
    input  logic [2:0]         in_funct3,
    input  logic [11:0]        in_imm,
    input  logic               in_last,
    output logic               imem_we,
    output logic [IMEM_AW-1:0] imem_addr,
    output logic [15:0]        imem_wdata,
    output logic               cpu_hold,
    output logic               done,
    output logic [IMEM_AW:0]   count,
    output logic               err_overflow
);

    localparam int               DEPTH     = 2 ** IMEM_AW;
    localparam logic [IMEM_AW:0] DEPTH_W   = (IMEM_AW + 1)'(DEPTH);
    localparam logic [IMEM_AW:0] ONE_W     = (IMEM_AW + 1)'(1);
    localparam logic [15:0]      HALT_WORD = 16'hF000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Packs the decoded fields into the instruction word the decoder expects.
    function automatic logic [15:0] encode_instr(
        input logic [3:0]  op,
        input logic [2:0]  rs,
        input logic [2:0]  rt,
        input logic [2:0]  rd,
        input logic [2:0]  f3,
        input logic [11:0] imm
    );
        logic [15:0] w;
        w = 16'h0000;
        case (op)
            4'h0, 4'h1:                      w = {op, rs, rt, rd, f3};
            4'h2, 4'h3:                      w = {op, rt, 1'b0, imm[7:0]};
            4'h4, 4'h5, 4'h6, 4'h7, 4'h8,
            4'h9, 4'hA, 4'hB, 4'hC:          w = {op, rs, rt, imm[5:0]};
            4'hD:                            w = {op, imm};
            default:                         w = {op, 12'h000};
        endcase
        return w;
    endfunction

    state_t               state_q, state_d;
    logic                 in_ready_q, in_ready_d;
    logic                 imem_we_q, imem_we_d;
    logic [IMEM_AW-1:0]   imem_addr_q, imem_addr_d;
    logic [15:0]          imem_wdata_q, imem_wdata_d;
    logic                 cpu_hold_q, cpu_hold_d;
    logic                 done_q, done_d;
    logic [IMEM_AW:0]     count_q, count_d;
    logic                 err_q, err_d;
`ifdef AUTO_HALT_EN
    logic                 need_halt_q, need_halt_d;
`endif

    logic                 accept_s;
    logic                 full_s;

    assign accept_s = in_valid & in_ready_q;
    assign full_s   = (count_q == DEPTH_W);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic for the load session sequence.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_LOAD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (accept_s && in_last) begin
                    state_d = ST_DRAIN;
                end else begin
                    state_d = ST_LOAD;
                end
            end
            ST_DRAIN: begin
`ifdef AUTO_HALT_EN
                // A pending HALT append keeps us here for one more cycle.
                if (need_halt_q) begin
                    state_d = ST_DRAIN;
                end else begin
                    state_d = ST_DONE;
                end
`else
                state_d = ST_DONE;
`endif
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Output and datapath next-values; everything is registered below.
    always_comb begin
        in_ready_d   = (state_d == ST_LOAD);
        imem_we_d    = 1'b0;
        imem_addr_d  = imem_addr_q;
        imem_wdata_d = imem_wdata_q;
        cpu_hold_d   = cpu_hold_q;
        done_d       = 1'b0;
        count_d      = count_q;
        err_d        = err_q;
`ifdef AUTO_HALT_EN
        need_halt_d  = need_halt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    count_d     = '0;
                    imem_addr_d = '0;
                    err_d       = 1'b0;
                    cpu_hold_d  = 1'b1;
`ifdef AUTO_HALT_EN
                    need_halt_d = 1'b0;
`endif
                end else begin
                    cpu_hold_d  = cpu_hold_q;
                end
            end
            ST_LOAD: begin
                cpu_hold_d = 1'b1;
                if (accept_s) begin
                    // A beat that finds memory full is dropped and flagged.
                    if (full_s) begin
                        err_d = 1'b1;
                    end else begin
                        imem_we_d    = 1'b1;
                        imem_addr_d  = count_q[IMEM_AW-1:0];
                        imem_wdata_d = encode_instr(in_opcode, in_rs, in_rt,
                                                    in_rd, in_funct3, in_imm);
                        count_d      = count_q + ONE_W;
                    end
`ifdef AUTO_HALT_EN
                    if (in_last) begin
                        need_halt_d = (in_opcode != 4'hF);
                    end else begin
                        need_halt_d = 1'b0;
                    end
`endif
                end else begin
                    imem_we_d = 1'b0;
                end
            end
            ST_DRAIN: begin
`ifdef AUTO_HALT_EN
                if (need_halt_q) begin
                    need_halt_d = 1'b0;
                    if (full_s) begin
                        err_d = 1'b1;
                    end else begin
                        imem_we_d    = 1'b1;
                        imem_addr_d  = count_q[IMEM_AW-1:0];
                        imem_wdata_d = HALT_WORD;
                        count_d      = count_q + ONE_W;
                    end
                end else begin
                    done_d     = 1'b1;
                    cpu_hold_d = 1'b0;
                end
`else
                done_d     = 1'b1;
                cpu_hold_d = 1'b0;
`endif
            end
            ST_DONE: begin
                cpu_hold_d = 1'b0;
            end
            default: begin
                cpu_hold_d = 1'b1;
            end
        endcase
    end

    // Output and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_ready_q   <= 1'b0;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= '0;
            imem_wdata_q <= 16'h0000;
            cpu_hold_q   <= 1'b1;
            done_q       <= 1'b0;
            count_q      <= '0;
            err_q        <= 1'b0;
`ifdef AUTO_HALT_EN
            need_halt_q  <= 1'b0;
`endif
        end else begin
            in_ready_q   <= in_ready_d;
            imem_we_q    <= imem_we_d;
            imem_addr_q  <= imem_addr_d;
            imem_wdata_q <= imem_wdata_d;
            cpu_hold_q   <= cpu_hold_d;
            done_q       <= done_d;
            count_q      <= count_d;
            err_q        <= err_d;
`ifdef AUTO_HALT_EN
            need_halt_q  <= need_halt_d;
`endif
        end
    end

    assign in_ready     = in_ready_q;
    assign imem_we      = imem_we_q;
    assign imem_addr    = imem_addr_q;
    assign imem_wdata   = imem_wdata_q;
    assign cpu_hold     = cpu_hold_q;
    assign done         = done_q;
    assign count        = count_q;
    assign err_overflow = err_q;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Bench for instr_encoder_loader: a full-size instance (IMEM_AW=8) and a
// tiny instance (IMEM_AW=2) share the same stimulus. Expected words come
// from an arithmetic model of the encoding table.
module tb_instr_encoder_loader;

    typedef struct {
        logic [3:0]  op;
        logic [2:0]  rs;
        logic [2:0]  rt;
        logic [2:0]  rd;
        logic [2:0]  f3;
        logic [11:0] imm;
        logic        last;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst, start, in_valid, in_last;
    logic [3:0]  in_opcode;
    logic [2:0]  in_rs, in_rt, in_rd, in_funct3;
    logic [11:0] in_imm;

    logic        in_ready_a, imem_we_a, cpu_hold_a, done_a, err_a;
    logic [7:0]  imem_addr_a;
    logic [15:0] imem_wdata_a;
    logic [8:0]  count_a;

    logic        in_ready_b, imem_we_b, cpu_hold_b, done_b, err_b;
    logic [1:0]  imem_addr_b;
    logic [15:0] imem_wdata_b;
    logic [2:0]  count_b;

    int n_assert = 0;
    int n_fail   = 0;

    int          cyc = 0;
    int          acc_cyc[$];
    int          wa_cyc[$];
    int          wa_addr[$];
    logic [15:0] wa_data[$];
    int          wb_addr[$];
    logic [15:0] wb_data[$];
    int          dones_a = 0;

    beat_t beats[$];
    int    last_exp_cnt = 0;

    instr_encoder_loader #(.IMEM_AW(8)) dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready_a),
        .in_opcode(in_opcode), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
        .in_funct3(in_funct3), .in_imm(in_imm), .in_last(in_last),
        .imem_we(imem_we_a), .imem_addr(imem_addr_a), .imem_wdata(imem_wdata_a),
        .cpu_hold(cpu_hold_a), .done(done_a), .count(count_a), .err_overflow(err_a)
    );

    instr_encoder_loader #(.IMEM_AW(2)) dut_small (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready_b),
        .in_opcode(in_opcode), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
        .in_funct3(in_funct3), .in_imm(in_imm), .in_last(in_last),
        .imem_we(imem_we_b), .imem_addr(imem_addr_b), .imem_wdata(imem_wdata_b),
        .cpu_hold(cpu_hold_b), .done(done_b), .count(count_b), .err_overflow(err_b)
    );

    always #5 clk = ~clk;

    // Logs handshakes, memory writes and done pulses at each rising edge.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (in_valid && in_ready_a) acc_cyc.push_back(cyc);
        if (imem_we_a) begin
            wa_cyc.push_back(cyc);
            wa_addr.push_back(32'(imem_addr_a));
            wa_data.push_back(imem_wdata_a);
        end
        if (imem_we_b) begin
            wb_addr.push_back(32'(imem_addr_b));
            wb_data.push_back(imem_wdata_b);
        end
        if (done_a) dones_a <= dones_a + 1;
    end

    // Reference encoding, written as field weights from the ISA table.
    function automatic logic [15:0] enc(input beat_t b);
        int op, rs, rt, rd, f3, imm, w;
        op = 32'(b.op); rs = 32'(b.rs); rt = 32'(b.rt);
        rd = 32'(b.rd); f3 = 32'(b.f3); imm = 32'(b.imm);
        if (op <= 1)       w = op * 4096 + rs * 512 + rt * 64 + rd * 8 + f3;
        else if (op <= 3)  w = op * 4096 + rt * 512 + (imm % 256);
        else if (op <= 12) w = op * 4096 + rs * 512 + rt * 64 + (imm % 64);
        else if (op == 13) w = op * 4096 + imm;
        else               w = op * 4096;
        return 16'(w);
    endfunction

    function automatic beat_t mk(input int op, input int rs, input int rt, input int rd,
                                 input int f3, input int imm, input bit last);
        beat_t b;
        b.op = 4'(op); b.rs = 3'(rs); b.rt = 3'(rt); b.rd = 3'(rd);
        b.f3 = 3'(f3); b.imm = 12'(imm); b.last = last;
        return b;
    endfunction

    function automatic beat_t rnd_beat(input bit last);
        return mk($urandom_range(0, 15), $urandom_range(0, 7), $urandom_range(0, 7),
                  $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 4095), last);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input beat_t b);
        in_opcode = b.op; in_rs = b.rs; in_rt = b.rt; in_rd = b.rd;
        in_funct3 = b.f3; in_imm = b.imm; in_last = b.last;
    endtask

    task automatic fill_random(input int n);
        beats.delete();
        for (int i = 0; i < n; i++) beats.push_back(rnd_beat(i == n - 1));
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Presents one beat with in_valid held high until it is taken.
    task automatic send_fixed(input beat_t b);
        bit rdy;
        int to;
        to = 0;
        in_valid = 1'b1;
        drive(b);
        rdy = in_ready_a;
        while (!rdy && to < 64) begin
            @(posedge clk); #1;
            rdy = in_ready_a;
            to++;
        end
        if (!rdy) chk("accept_timeout", 32'(to), 32'd0);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Runs a whole session from the global beat list and checks both instances.
    task automatic run_session(input bit rnd, input int mid);
        logic [15:0] exp_w[$];
        int          base_a, base_b, base_acc, base_done, nb, to, nbeats;
        bit          acc, rdy, v;
        nbeats = beats.size();
        foreach (beats[i]) exp_w.push_back(enc(beats[i]));
`ifdef AUTO_HALT_EN
        if (beats[nbeats-1].op != 4'hF) exp_w.push_back(16'hF000);
`endif
        base_a = wa_data.size(); base_b = wb_data.size();
        base_acc = acc_cyc.size(); base_done = dones_a;
        pulse_start();
        chk("load_hold", 32'(cpu_hold_a), 32'd1);
        chk("load_ready", 32'(in_ready_a), 32'd1);
        for (int i = 0; i < nbeats; i++) begin
            if (i == mid) begin
                in_valid = 1'b0;
                pulse_start();
                chk("restart_ignored_count", 32'(count_a), 32'(mid));
                chk("restart_ignored_ready", 32'(in_ready_a), 32'd1);
            end
            acc = 1'b0;
            to = 0;
            while (!acc) begin
                if (rnd && $urandom_range(0, 2) == 0) begin
                    in_valid = 1'b0;
                end else begin
                    in_valid = 1'b1;
                    drive(beats[i]);
                end
                v = in_valid; rdy = in_ready_a;
                @(posedge clk); #1;
                acc = v && rdy;
                to++;
                if (!acc && to > 64) begin
                    chk("accept_timeout", 32'(to), 32'd0);
                    in_valid = 1'b0;
                    return;
                end
            end
        end
        in_valid = 1'b0;
        to = 0;
        while (dones_a == base_done && to < 16) begin
            @(posedge clk); #1;
            to++;
        end
        repeat (2) @(posedge clk);
        #1;
        last_exp_cnt = exp_w.size();
        chk("done_pulses", 32'(dones_a - base_done), 32'd1);
        chk("hold_released", 32'(cpu_hold_a), 32'd0);
        chk("ready_idle", 32'(in_ready_a), 32'd0);
        chk("count", 32'(count_a), 32'(exp_w.size()));
        chk("err_overflow", 32'(err_a), 32'd0);
        chk("n_accepts", 32'(acc_cyc.size() - base_acc), 32'(nbeats));
        chk("n_writes", 32'(wa_data.size() - base_a), 32'(exp_w.size()));
        for (int i = 0; i < exp_w.size() && base_a + i < wa_data.size(); i++) begin
            chk("wr_addr", 32'(wa_addr[base_a+i]), 32'(i));
            chk("wr_data", 32'(wa_data[base_a+i]), 32'(exp_w[i]));
        end
        for (int i = 0; i < nbeats && base_a + i < wa_cyc.size()
                        && base_acc + i < acc_cyc.size(); i++)
            chk("wr_latency", 32'(wa_cyc[base_a+i] - acc_cyc[base_acc+i]), 32'd1);
        if (exp_w.size() > nbeats && base_a + nbeats < wa_cyc.size()
                && base_acc + nbeats - 1 < acc_cyc.size())
            chk("halt_latency", 32'(wa_cyc[base_a+nbeats] - acc_cyc[base_acc+nbeats-1]), 32'd2);
        nb = (exp_w.size() < 4) ? exp_w.size() : 4;
        chk("small_count", 32'(count_b), 32'(nb));
        chk("small_err", 32'(err_b), 32'(exp_w.size() > 4));
        chk("small_done_hold", 32'(cpu_hold_b), 32'd0);
        chk("small_n_writes", 32'(wb_data.size() - base_b), 32'(nb));
        for (int i = 0; i < nb && base_b + i < wb_data.size(); i++) begin
            chk("small_wr_addr", 32'(wb_addr[base_b+i]), 32'(i));
            chk("small_wr_data", 32'(wb_data[base_b+i]), 32'(exp_w[i]));
        end
    endtask

    initial begin
        int base_w;
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        in_opcode = 4'h0; in_rs = 3'd0; in_rt = 3'd0; in_rd = 3'd0;
        in_funct3 = 3'd0; in_imm = 12'h000;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(in_ready_a), 32'd0);
        chk("rst_imem_we", 32'(imem_we_a), 32'd0);
        chk("rst_imem_addr", 32'(imem_addr_a), 32'd0);
        chk("rst_imem_wdata", 32'(imem_wdata_a), 32'd0);
        chk("rst_cpu_hold", 32'(cpu_hold_a), 32'd1);
        chk("rst_done", 32'(done_a), 32'd0);
        chk("rst_count", 32'(count_a), 32'd0);
        chk("rst_err", 32'(err_a), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // T1: ADD, ADDI, HALT
        beats.delete();
        beats.push_back(mk(0, 1, 2, 3, 0, 0, 1'b0));
        beats.push_back(mk(4, 1, 2, 0, 0, 12'hFFD, 1'b0));
        beats.push_back(mk(15, 0, 0, 0, 0, 0, 1'b1));
        base_w = wa_data.size();
        run_session(1'b0, -1);
        if (wa_data.size() >= base_w + 3) begin
            chk("t1_add", 32'(wa_data[base_w]), 32'h0298);
            chk("t1_addi", 32'(wa_data[base_w+1]), 32'h42BD);
            chk("t1_halt", 32'(wa_data[base_w+2]), 32'hF000);
        end else begin
            chk("t1_writes", 32'(wa_data.size() - base_w), 32'd3);
        end

        // T2: LHI then CALL with last
        beats.delete();
        beats.push_back(mk(2, 0, 5, 0, 0, 12'h0AB, 1'b0));
        beats.push_back(mk(13, 0, 0, 0, 0, 12'h123, 1'b1));
        base_w = wa_data.size();
        run_session(1'b0, -1);
        if (wa_data.size() >= base_w + 2) begin
            chk("t2_lhi", 32'(wa_data[base_w]), 32'h2AAB);
            chk("t2_call", 32'(wa_data[base_w+1]), 32'hD123);
        end else begin
            chk("t2_writes", 32'(wa_data.size() - base_w), 32'd2);
        end

        // T3: random beats with in_valid toggling
        for (int k = 0; k < 3; k++) begin
            fill_random(8 + k * 3);
            run_session(1'b1, -1);
        end

        // T4: overflow of the small instance
        fill_random(6);
        run_session(1'b0, -1);
        fill_random(4);
        beats[3].op = 4'hF;
        run_session(1'b1, -1);

        // T5: reset after two of five beats
        fill_random(5);
        pulse_start();
        send_fixed(beats[0]);
        send_fixed(beats[1]);
        rst = 1'b1;
        #1;
        chk("t5_hold", 32'(cpu_hold_a), 32'd1);
        chk("t5_we", 32'(imem_we_a), 32'd0);
        chk("t5_count", 32'(count_a), 32'd0);
        chk("t5_ready", 32'(in_ready_a), 32'd0);
        chk("t5_small_count", 32'(count_b), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        fill_random(5);
        run_session(1'b0, -1);

        // T6: start during LOAD, then a beat offered in IDLE
        fill_random(5);
        run_session(1'b0, 2);
        base_w = wa_data.size();
        in_valid = 1'b1;
        drive(rnd_beat(1'b1));
        repeat (4) @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("t6_idle_no_write", 32'(wa_data.size() - base_w), 32'd0);
        chk("t6_idle_count", 32'(count_a), 32'(last_exp_cnt));
        chk("t6_idle_ready", 32'(in_ready_a), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
